// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS core: FSM state codes, opcodes,
// ALU/mux select encodings and the packed control word driven to the datapath.
package mips_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_ADDIEX = 4'd10,
    S_ADDIWB = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;

  localparam logic [1:0] SRCB_B       = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // Datapath control word; IllegalOp is handled separately because it is
  // the only output that depends on Op.
  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
  } ctrl_t;

  localparam int CTRL_W = $bits(ctrl_t);

  function automatic logic op_supported(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
           (op == OP_BEQ)   || (op == OP_J)  || (op == OP_ADDI);
  endfunction

endpackage

// File: rtl/multicycle_control_outdec.sv
// Moore output decoder: maps the registered state code to the datapath
// control word. Unused codes 12-15 decode to all-zero.
module multicycle_control_outdec
  import mips_pkg::*;
(
  input  logic [3:0]        state_i,
  output logic [CTRL_W-1:0] ctrl_o
);

  ctrl_t c;

  // Per-state control word; every field defaults to 0 first.
  always_comb begin
    c = '0;
    case (state_i)
      S_FETCH: begin
        c.mem_read  = 1'b1;
        c.ir_write  = 1'b1;
        c.alu_src_b = SRCB_FOUR;
        c.alu_op    = ALUOP_ADD;
        c.pc_write  = 1'b1;
        c.pc_source = PCSRC_ALU;
      end
      S_DECODE: begin
        // Branch target computed speculatively into ALUOut.
        c.alu_src_b = SRCB_IMM_SH2;
        c.alu_op    = ALUOP_ADD;
      end
      S_MEMADR: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_IMM;
        c.alu_op    = ALUOP_ADD;
      end
      S_MEMRD: begin
        c.mem_read = 1'b1;
        c.iord     = 1'b1;
      end
      S_MEMWB: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        c.mem_write = 1'b1;
        c.iord      = 1'b1;
      end
      S_EXEC: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_B;
        c.alu_op    = ALUOP_RTYPE;
      end
      S_ALUWB: begin
        c.reg_write = 1'b1;
        c.reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        c.alu_src_a     = 1'b1;
        c.alu_src_b     = SRCB_B;
        c.alu_op        = ALUOP_SUB;
        c.pc_write_cond = 1'b1;
        c.pc_source     = PCSRC_ALUOUT;
      end
      S_JUMP: begin
        c.pc_write  = 1'b1;
        c.pc_source = PCSRC_JUMP;
      end
      S_ADDIEX: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_IMM;
        c.alu_op    = ALUOP_ADD;
      end
      S_ADDIWB: begin
        c.reg_write = 1'b1;
      end
      default: c = '0;
    endcase
  end

  assign ctrl_o = c;

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM of the multicycle MIPS core. Holds the state register and
// next-state logic; outputs are a Moore decode of the state, forced to zero
// combinationally while rst_n is low so no write can occur in a reset cycle.
module multicycle_control
  import mips_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] Op,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSource,
  output logic       IllegalOp,
  output logic [3:0] State
);

  state_t            state_q, state_d;
  logic [CTRL_W-1:0] ctrl_raw;
  ctrl_t             ctrl;

  // State register with synchronous active-low reset to FETCH.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  // Next-state logic; Op is consulted only in DECODE and MEMADR.
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (Op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXEC;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          OP_ADDI:      state_d = S_ADDIEX;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR: state_d = (Op == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  state_d = S_MEMWB;
      S_EXEC:   state_d = S_ALUWB;
      S_ADDIEX: state_d = S_ADDIWB;
      default:  state_d = S_FETCH;
    endcase
  end

  multicycle_control_outdec u_outdec (
    .state_i (state_q),
    .ctrl_o  (ctrl_raw)
  );

  assign ctrl = rst_n ? ctrl_t'(ctrl_raw) : ctrl_t'('0);

  assign PCWrite     = ctrl.pc_write;
  assign PCWriteCond = ctrl.pc_write_cond;
  assign IorD        = ctrl.iord;
  assign MemRead     = ctrl.mem_read;
  assign MemWrite    = ctrl.mem_write;
  assign IRWrite     = ctrl.ir_write;
  assign MemtoReg    = ctrl.mem_to_reg;
  assign RegDst      = ctrl.reg_dst;
  assign RegWrite    = ctrl.reg_write;
  assign ALUSrcA     = ctrl.alu_src_a;
  assign ALUSrcB     = ctrl.alu_src_b;
  assign ALUOp       = ctrl.alu_op;
  assign PCSource    = ctrl.pc_source;

  // The only Op-dependent output: flags an unsupported opcode in DECODE.
  assign IllegalOp = rst_n && (state_q == S_DECODE) && !op_supported(Op);

  assign State = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: walks each instruction class through
// its state sequence and compares the full control word every cycle against a
// table written from the state/output list.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] Op;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic       MemtoReg, RegDst, RegWrite, ALUSrcA, IllegalOp;
  logic [1:0] ALUSrcB, ALUOp, PCSource;
  logic [3:0] State;

  int n_checks = 0;
  int n_fail   = 0;
  logic mon_en = 1'b0;

  logic [3:0] exp_q[$];

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  multicycle_control dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .Op          (Op),
    .PCWrite     (PCWrite),
    .PCWriteCond (PCWriteCond),
    .IorD        (IorD),
    .MemRead     (MemRead),
    .MemWrite    (MemWrite),
    .IRWrite     (IRWrite),
    .MemtoReg    (MemtoReg),
    .RegDst      (RegDst),
    .RegWrite    (RegWrite),
    .ALUSrcA     (ALUSrcA),
    .ALUSrcB     (ALUSrcB),
    .ALUOp       (ALUOp),
    .PCSource    (PCSource),
    .IllegalOp   (IllegalOp),
    .State       (State)
  );

  // Packed view of all control outputs, bench-side ordering.
  logic [16:0] dut_word;
  assign dut_word = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
                     MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp,
                     PCSource, IllegalOp};

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- expected-value model ----------------
  function automatic logic [16:0] model(input logic [3:0] s, input logic [5:0] op);
    logic pcw, pcwc, iord, mr, mw, irw, m2r, rdst, rw, sa, ill;
    logic [1:0] sb, aop, pcs;
    {pcw, pcwc, iord, mr, mw, irw, m2r, rdst, rw, sa, ill} = '0;
    sb = 2'b00; aop = 2'b00; pcs = 2'b00;
    case (s)
      4'd0:  begin mr = 1; irw = 1; sb = 2'b01; pcw = 1; end
      4'd1:  begin sb = 2'b11;
                   ill = !(op inside {6'b000000, 6'b100011, 6'b101011,
                                      6'b000100, 6'b000010, 6'b001000}); end
      4'd2:  begin sa = 1; sb = 2'b10; end
      4'd3:  begin mr = 1; iord = 1; end
      4'd4:  begin rw = 1; m2r = 1; end
      4'd5:  begin mw = 1; iord = 1; end
      4'd6:  begin sa = 1; aop = 2'b10; end
      4'd7:  begin rw = 1; rdst = 1; end
      4'd8:  begin sa = 1; aop = 2'b01; pcwc = 1; pcs = 2'b01; end
      4'd9:  begin pcw = 1; pcs = 2'b10; end
      4'd10: begin sa = 1; sb = 2'b10; end
      4'd11: begin rw = 1; end
      default: ;
    endcase
    return {pcw, pcwc, iord, mr, mw, irw, m2r, rdst, rw, sa, sb, aop, pcs, ill};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Consume exp_q: each entry is the state expected in successive cycles.
  task automatic run_seq(input logic [5:0] op, input string name);
    logic [3:0] s;
    Op = op;
    while (exp_q.size() > 0) begin
      s = exp_q.pop_front();
      check({name, "_state"}, 32'(State), 32'(s));
      check({name, "_word"}, 32'(dut_word), 32'(model(s, op)));
      step();
    end
  endtask

  task automatic run_instr(input logic [5:0] op, input string name);
    run_seq(op, name);
    check({name, "_back_to_fetch"}, 32'(State), 32'd0);
  endtask

  // Per-cycle invariants.
  always @(negedge clk) begin
    if (mon_en) begin
      check("memrd_memwr_excl", 32'(MemRead & MemWrite), 32'd0);
      check("regwr_memwr_excl", 32'(RegWrite & MemWrite), 32'd0);
      check("state_in_range", 32'(State <= 4'd11), 32'd1);
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0;
    Op    = 6'b100011;
    step();
    mon_en = 1'b1;
    step();
    step();
    check("reset_state", 32'(State), 32'd0);
    check("reset_word", 32'(dut_word), 32'd0);

    rst_n = 1'b1;
    #1;
    check("first_fetch_memread", 32'(MemRead), 32'd1);
    check("first_fetch_irwrite", 32'(IRWrite), 32'd1);
    check("first_fetch_pcwrite", 32'(PCWrite), 32'd1);
    check("first_fetch_srcb", 32'(ALUSrcB), 32'd1);

    exp_q = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4};
    run_instr(6'b100011, "lw");
    exp_q = '{4'd0, 4'd1, 4'd2, 4'd5};
    run_instr(6'b101011, "sw");
    exp_q = '{4'd0, 4'd1, 4'd6, 4'd7};
    run_instr(6'b000000, "rtype");
    exp_q = '{4'd0, 4'd1, 4'd10, 4'd11};
    run_instr(6'b001000, "addi");
    exp_q = '{4'd0, 4'd1, 4'd8};
    run_instr(6'b000100, "beq");
    exp_q = '{4'd0, 4'd1, 4'd9};
    run_instr(6'b000010, "j");
    exp_q = '{4'd0, 4'd1};
    run_instr(6'b111111, "illegal");
    check("illegal_pulse_gone", 32'(IllegalOp), 32'd0);
    exp_q = '{4'd0, 4'd1};
    run_instr(6'b010001, "illegal2");

    // Reset asserted while in MEMWR.
    exp_q = '{4'd0, 4'd1, 4'd2};
    run_seq(6'b101011, "sw_rst");
    check("memwr_reached", 32'(State), 32'd5);
    check("memwr_memwrite", 32'(MemWrite), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst_gates_memwrite", 32'(MemWrite), 32'd0);
    check("rst_gates_word", 32'(dut_word), 32'd0);
    step();
    check("rst_next_state", 32'(State), 32'd0);
    check("rst_next_word", 32'(dut_word), 32'd0);
    rst_n = 1'b1;
    #1;

    exp_q = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4};
    run_instr(6'b100011, "lw_after_rst");

    mon_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Safety bound so the run always terminates.
  initial begin
    #20000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Main control FSM for the multicycle MIPS core. It decodes the 6-bit opcode latched in the instruction register and steps the shared datapath through Fetch / Decode / Execute / Memory / Writeback. The datapath is one shared memory, one register file, and one ALU driven via alu_control. Each cycle it drives every datapath enable and mux select as a Moore function of the current state.

## Interface
Parameters:
- none; opcode and encoding constants come from `mips_pkg`.

Ports:
- `clk`  in  1  system clock, rising-edge
- `rst_n`  in  1  reset, synchronous, active-low
- `Op`  in  6  opcode field, IR[31:26]
- `PCWrite`  out  1  unconditional PC load
- `PCWriteCond`  out  1  PC load qualified by ALU Zero (beq)
- `IorD`  out  1  memory address select: 0 = PC, 1 = ALUOut
- `MemRead`  out  1  memory read enable
- `MemWrite`  out  1  memory write enable
- `IRWrite`  out  1  instruction register load
- `MemtoReg`  out  1  register write data select: 0 = ALUOut, 1 = MDR
- `RegDst`  out  1  destination register select: 0 = rt, 1 = rd
- `RegWrite`  out  1  register file write enable
- `ALUSrcA`  out  1  ALU A select: 0 = PC, 1 = A register
- `ALUSrcB`  out  2  ALU B select: 00 = B register, 01 = constant 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2
- `ALUOp`  out  2  00 = add, 01 = sub, 10 = R-type (funct decides)
- `PCSource`  out  2  PC input select: 00 = ALU result, 01 = ALUOut, 10 = jump target
- `IllegalOp`  out  1  one-cycle pulse in DECODE when the opcode is unsupported
- `State`  out  4  current state code, for debug and verification

## Operation
Supported opcodes:
- R-type 000000
- lw 100011
- sw 101011
- beq 000100
- j 000010
- addi 001000

Each state asserts only the outputs listed; every other output is 0.
- FETCH(0): MemRead, IRWrite, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCWrite, PCSource=00 → DECODE.
- DECODE(1): ALUSrcA=0, ALUSrcB=11, ALUOp=00 (branch target into ALUOut). Next state by Op:
  - lw/sw → MEMADR
  - R → EXEC
  - beq → BRANCH
  - j → JUMP
  - addi → ADDIEX
  - any other opcode → FETCH, with IllegalOp=1
- MEMADR(2): ALUSrcA=1, ALUSrcB=10, ALUOp=00. lw → MEMRD; sw → MEMWR.
- MEMRD(3): MemRead, IorD=1 → MEMWB.
- MEMWB(4): RegWrite, RegDst=0, MemtoReg=1 → FETCH.
- MEMWR(5): MemWrite, IorD=1 → FETCH.
- EXEC(6): ALUSrcA=1, ALUSrcB=00, ALUOp=10 → ALUWB.
- ALUWB(7): RegWrite, RegDst=1, MemtoReg=0 → FETCH.
- BRANCH(8): ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond, PCSource=01 → FETCH.
- JUMP(9): PCWrite, PCSource=10 → FETCH.
- ADDIEX(10): ALUSrcA=1, ALUSrcB=10, ALUOp=00 → ADDIWB.
- ADDIWB(11): RegWrite, RegDst=0, MemtoReg=0 → FETCH.
- Unused state codes 12–15 → FETCH next cycle, with all outputs 0.
- `Op` is sampled only in DECODE and MEMADR; the IR is stable there because IRWrite is asserted only in FETCH.

## Timing
- Synchronous reset: while `rst_n`=0 the state register loads FETCH on each clk edge, and all control outputs are forced to 0. `State` reads 0.
- The first FETCH outputs appear in the first cycle with `rst_n`=1.
- Reset asserted mid-instruction: the next edge goes to FETCH and outputs are 0 immediately (combinational gating). No partial write may occur in the reset cycle.
- Cycles per instruction, FETCH through last state inclusive:
  - lw 5
  - sw 4
  - R-type 4
  - addi 4
  - beq 3
  - j 3
  - illegal 2
- Outputs are a pure decode of the registered state; there is no combinational path from `Op` to any output except `IllegalOp` (DECODE only).
- MemRead and MemWrite are never asserted in the same cycle. RegWrite and MemWrite are never asserted in the same cycle.

## Structure
- `mips_pkg` holds:
  - the `state_t` enum (4-bit, codes as above)
  - opcode localparams (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI)
  - ALUOp, ALUSrcB and PCSource encodings, shared with alu_control and the datapath.
- Sub-module `multicycle_control_outdec`: a combinational state → control-word decoder. The top level holds only the state register, next-state logic and reset gating.

## Test plan
- Reset held 3 cycles with Op=100011: all outputs 0 and State=0. After release, cycle 1 shows MemRead=IRWrite=PCWrite=1, ALUSrcB=01.
- Op=100011 (lw): State sequence 0,1,2,3,4,0. In MEMWB, RegWrite=1, MemtoReg=1, RegDst=0. Op=101011 (sw): sequence 0,1,2,5,0, with MemWrite=1 and IorD=1 in state 5.
- Op=000000: sequence 0,1,6,7,0, with ALUOp=10 in EXEC and RegDst=1 in ALUWB. Op=001000: sequence 0,1,10,11,0.
- Op=000100: sequence 0,1,8,0, with PCWriteCond=1, ALUOp=01, PCSource=01 in BRANCH. Op=000010: sequence 0,1,9,0, with PCWrite=1 and PCSource=10.
- Op=111111: IllegalOp=1 for exactly one cycle in DECODE, then State=0. Also deassert `rst_n` while in MEMWR: MemWrite=0 that cycle and State=0 on the next edge.
- Every cycle, assert that MemRead and MemWrite are never both 1, and that `State` never leaves codes 0–11.
